// File: rtl/pll_lock_seq.sv
// PLL power-up / relock sequencer on the reference clock: pulses the PLL reset, waits for a
// continuously stable lock, then releases the system reset. Retries on lock timeout.
module pll_lock_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 16000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned RETRY_W        = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LOCK,
  output logic               PLL_RESETB,
  output logic               SYS_RESET,
  output logic               READY,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic               LOCK_LOST
);

  localparam int unsigned MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYCLES = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StPllRst,
    StWaitLk,
    StStable,
    StRun
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lost_d;
  logic               lock_meta_q, lock_s_q;

  always_comb begin
    state_d = state_q;
    retry_d = RETRY_CNT;
    lost_d  = LOCK_LOST;
    case (state_q)
      StPllRst: begin
        if (cnt_q == RST_LAST) state_d = StWaitLk;
      end
      StWaitLk: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s_q) begin
          state_d = StStable;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = StPllRst;
          if (RETRY_CNT != '1) retry_d = RETRY_CNT + RETRY_W'(1);
        end
      end
      StStable: begin
        if (!lock_s_q) begin
          state_d = StWaitLk;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lock_s_q) begin
          state_d = StPllRst;
          lost_d  = 1'b1;
        end
      end
      default: state_d = StPllRst;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StRun) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= StPllRst;
      cnt_q       <= '0;
      PLL_RESETB  <= 1'b0;
      SYS_RESET   <= 1'b1;
      READY       <= 1'b0;
      RETRY_CNT   <= '0;
      LOCK_LOST   <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      PLL_RESETB  <= (state_d != StPllRst);
      SYS_RESET   <= (state_d != StRun);
      READY       <= (state_d == StRun);
      RETRY_CNT   <= retry_d;
      LOCK_LOST   <= lost_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: a table of {inputs, cycle count, expected outputs} steps driven in
// order, with expectations queued at drive time and popped when the outputs are sampled.
module tb_pll_lock_seq;

  localparam int unsigned TIMEOUT = 200;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LOCK = 1'b0;
  logic       PLL_RESETB, SYS_RESET, READY, LOCK_LOST;
  logic [3:0] RETRY_CNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          rst;
    bit          lock;
    int unsigned cycles;
    bit          resetb;
    bit          sys;
    bit          ready;
    logic [3:0]  retry;
    bit          lost;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  pll_lock_seq #(
    .PLL_RST_CYCLES(16),
    .LOCK_TIMEOUT  (TIMEOUT),
    .STABLE_CYCLES (1024),
    .RETRY_W       (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .LOCK      (LOCK),
    .PLL_RESETB(PLL_RESETB),
    .SYS_RESET (SYS_RESET),
    .READY     (READY),
    .RETRY_CNT (RETRY_CNT),
    .LOCK_LOST (LOCK_LOST)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(string name, bit rst, bit lock, int unsigned cycles, bit resetb,
                              bit sys, bit ready, logic [3:0] retry, bit lost);
    vec_t v;
    v.name = name; v.rst = rst; v.lock = lock; v.cycles = cycles;
    v.resetb = resetb; v.sys = sys; v.ready = ready; v.retry = retry; v.lost = lost;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, string field, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    RESET = v.rst;
    LOCK  = v.lock;
    sb.push_back(v);
    repeat (v.cycles) @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk(e.name, "pll_resetb", {7'd0, PLL_RESETB}, {7'd0, e.resetb});
    chk(e.name, "sys_reset", {7'd0, SYS_RESET}, {7'd0, e.sys});
    chk(e.name, "ready", {7'd0, READY}, {7'd0, e.ready});
    chk(e.name, "retry_cnt", {4'd0, RETRY_CNT}, {4'd0, e.retry});
    chk(e.name, "lock_lost", {7'd0, LOCK_LOST}, {7'd0, e.lost});
  endtask

  initial begin
    vec_t fin;
    logic [3:0] sat;

    // Power-up: PLL reset low exactly 16 cycles, then lock after 100 cycles.
    add("reset",          1, 0, 4,    0, 1, 0, 0, 0);
    add("pllrst_hold",    0, 0, 15,   0, 1, 0, 0, 0);
    add("pllrst_release", 0, 0, 1,    1, 1, 0, 0, 0);
    add("waitlk_100",     0, 0, 100,  1, 1, 0, 0, 0);
    add("stable_1026",    0, 1, 1026, 1, 1, 0, 0, 0);
    add("run_1027",       0, 1, 1,    1, 0, 1, 0, 0);
    // Lock lost in RUN: SYS_RESET rises on the 3rd edge.
    add("loss_2edges",    0, 0, 2,    1, 0, 1, 0, 0);
    add("loss_3rd",       0, 0, 1,    0, 1, 0, 0, 1);
    add("relock_hold",    0, 0, 15,   0, 1, 0, 0, 1);
    add("relock_release", 0, 0, 1,    1, 1, 0, 0, 1);
    // Short lock drop at STABLE count 500 restarts the full window.
    add("stable_500",     0, 1, 503,  1, 1, 0, 0, 1);
    add("glitch_5",       0, 0, 5,    1, 1, 0, 0, 1);
    add("restart_1026",   0, 1, 1026, 1, 1, 0, 0, 1);
    add("restart_run",    0, 1, 1,    1, 0, 1, 0, 1);
    // Reset in RUN with lock still high.
    add("reset_in_run",   1, 1, 1,    0, 1, 0, 0, 0);
    add("rst2_hold",      0, 0, 15,   0, 1, 0, 0, 0);
    add("rst2_release",   0, 0, 1,    1, 1, 0, 0, 0);
    // Lock timeouts and retries.
    add("to_199",         0, 0, TIMEOUT - 1, 1, 1, 0, 0, 0);
    add("timeout_1",      0, 0, 1,    0, 1, 0, 1, 0);
    add("retry1_hold",    0, 0, 15,   0, 1, 0, 1, 0);
    add("retry1_release", 0, 0, 1,    1, 1, 0, 1, 0);
    add("timeout_2",      0, 0, TIMEOUT, 0, 1, 0, 2, 0);
    add("retry2_release", 0, 0, 16,   1, 1, 0, 2, 0);
    // Lock seen on the timeout edge: STABLE, no retry counted.
    add("pre_timeout",    0, 0, TIMEOUT - 3, 1, 1, 0, 2, 0);
    add("lock_wins",      0, 1, 3,    1, 1, 0, 2, 0);
    // Lock drops on the STABLE completion edge: back to WAITLK, not RUN.
    add("pre_done",       0, 1, 1021, 1, 1, 0, 2, 0);
    add("drop_at_done",   0, 0, 3,    1, 1, 0, 2, 0);
    for (int r = 3; r <= 16; r++) begin
      sat = (r > 15) ? 4'd15 : 4'(r);
      add($sformatf("timeout_%0d", r), 0, 0, TIMEOUT, 0, 1, 0, sat, 0);
      add($sformatf("retry%0d_release", r), 0, 0, 16, 1, 1, 0, sat, 0);
    end

    foreach (vecs[i]) apply(vecs[i]);

    // Reset clears a saturated retry count.
    fin.name = "final_reset"; fin.rst = 1; fin.lock = 0; fin.cycles = 1;
    fin.resetb = 0; fin.sys = 1; fin.ready = 0; fin.retry = 4'd0; fin.lost = 0;
    apply(fin);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
